// File: rtl/ahb_region_decoder_mux.sv
// AHB region decoder and response multiplexer.
// Decodes HADDR[31:16] against programmable windows. Routes the data phase
// back from the selected slave. Contains a built-in default slave that
// answers with a two-cycle ERROR, plus a saturating decode-error counter.

// Single address window: unsigned base <= addr < limit, optionally boot-masked.
module ahb_region_match #(
  parameter logic [15:0] BASE      = 16'h0000,
  parameter logic [15:0] LIMIT     = 16'h0000,
  parameter logic        BOOT_MASK = 1'b0
) (
  input  logic [15:0] addr_hi,
  input  logic        sel,
  input  logic        boot,
  output logic        hit
);
  // The compares are done through 17-bit differences, so a zero base or an
  // all-ones limit never turns into a constant-folded compare.
  logic [16:0] d_base, d_limit;

  assign d_base  = {1'b0, addr_hi} - {1'b0, BASE};
  assign d_limit = {1'b0, addr_hi} - {1'b0, LIMIT};
  assign hit     = sel && !d_base[16] && d_limit[16] && !(boot && BOOT_MASK);
endmodule

module ahb_region_decoder_mux #(
  parameter int                             NUM_SLV         = 4,
  parameter int                             NUM_REGIONS     = 8,
  parameter int                             SLV_IDX_W       = 2,
  parameter logic [16*NUM_REGIONS-1:0]      REGION_BASE     = {NUM_REGIONS{16'h0000}},
  parameter logic [16*NUM_REGIONS-1:0]      REGION_LIMIT    = {NUM_REGIONS{16'h0000}},
  parameter logic [SLV_IDX_W*NUM_REGIONS-1:0] REGION_SLV    = '0,
  parameter logic [NUM_REGIONS-1:0]         REGION_BOOTMASK = '0,
  parameter int                             ERRCNT_W        = 8
) (
  input  logic                    HCLK,
  input  logic                    HRESET,
  input  logic                    HSEL_i,
  input  logic [31:0]             HADDR_i,
  input  logic [1:0]              HTRANS_i,
  input  logic                    HREADY_i,
  input  logic                    CFG_BOOT,
  output logic [NUM_SLV-1:0]      HSEL_o,
  input  logic [NUM_SLV-1:0]      HREADYOUT_i,
  input  logic [NUM_SLV-1:0]      HRESP_i,
  input  logic [NUM_SLV*32-1:0]   HRDATA_i,
  output logic                    HREADYOUT_o,
  output logic                    HRESP_o,
  output logic [31:0]             HRDATA_o,
  output logic                    DEFSLV_ERR_o,
  output logic [ERRCNT_W-1:0]     ERRCNT_o
);

  typedef enum logic [1:0] {IDLE, ERR1, ERR2} state_t;

  logic [NUM_REGIONS-1:0]          hit;
  logic                            any_hit;
  logic [SLV_IDX_W-1:0]            sel_idx;
  logic [2**SLV_IDX_W-1:0]         idx_ok;
  logic                            sel_def;
  logic                            accept_err;
  logic [NUM_SLV-1:0][31:0]        rdata_v;

  logic                            dsel_valid;
  logic                            dsel_def;
  logic [SLV_IDX_W-1:0]            dsel_idx;
  logic                            def_active;
  state_t                          state, state_nxt;

  // Only the upper half-word is decoded; HTRANS[0] (SEQ vs NONSEQ) is irrelevant.
  logic unused_bits;
  assign unused_bits = &{1'b0, HADDR_i[15:0], HTRANS_i[0]};

  assign rdata_v = HRDATA_i;

  generate
    for (genvar r = 0; r < NUM_REGIONS; r++) begin : g_rgn
      ahb_region_match #(
        .BASE      (REGION_BASE[16*r +: 16]),
        .LIMIT     (REGION_LIMIT[16*r +: 16]),
        .BOOT_MASK (REGION_BOOTMASK[r])
      ) u_match (
        .addr_hi (HADDR_i[31:16]),
        .sel     (HSEL_i),
        .boot    (CFG_BOOT),
        .hit     (hit[r])
      );
    end
  endgenerate

  // Priority decode: scan from the top down, so the lowest hit region wins.
  always_comb begin
    any_hit = 1'b0;
    sel_idx = '0;
    for (int i = 0; i < 2**SLV_IDX_W; i++) idx_ok[i] = (i < NUM_SLV);
    for (int r = NUM_REGIONS-1; r >= 0; r--) begin
      if (hit[r]) begin
        any_hit = 1'b1;
        sel_idx = REGION_SLV[r*SLV_IDX_W +: SLV_IDX_W];
      end
    end
    sel_def = !any_hit || !idx_ok[sel_idx];
  end

  // One-hot address-phase select; zero when the default slave takes the access.
  always_comb begin
    HSEL_o = '0;
    if (!sel_def)
      for (int s = 0; s < NUM_SLV; s++)
        if (32'(sel_idx) == s) HSEL_o[s] = 1'b1;
  end

  assign accept_err = HREADY_i && HSEL_i && sel_def && HTRANS_i[1];

  // Data-phase selection register, advanced only when the bus accepts an address phase.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dsel_valid <= 1'b0;
      dsel_def   <= 1'b1;
      dsel_idx   <= '0;
      def_active <= 1'b0;
    end else if (HREADY_i) begin
      dsel_valid <= HSEL_i;
      dsel_def   <= sel_def;
      dsel_idx   <= sel_idx;
      def_active <= accept_err;
    end
  end

  // Default slave state register.
  always_ff @(posedge HCLK) begin
    if (HRESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // Default slave next state: ERR1 (wait, ERROR) then ERR2 (ready, ERROR).
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_err) state_nxt = ERR1;
      ERR1:    state_nxt = ERR2;
      ERR2:    state_nxt = accept_err ? ERR1 : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Saturating error counter, bumped on every entry into ERR1.
  always_ff @(posedge HCLK) begin
    if (HRESET)
      ERRCNT_o <= '0;
    else if (state_nxt == ERR1 && ERRCNT_o != '1)
      ERRCNT_o <= ERRCNT_o + ERRCNT_W'(1);
  end

  assign DEFSLV_ERR_o = (state == ERR1) && def_active;

  // Response mux: the registered slave when one is active, otherwise the default slave.
  always_comb begin
    HREADYOUT_o = (state != ERR1);
    HRESP_o     = (state != IDLE);
    HRDATA_o    = '0;
    if (dsel_valid && !dsel_def) begin
      for (int s = 0; s < NUM_SLV; s++) begin
        if (32'(dsel_idx) == s) begin
          HREADYOUT_o = HREADYOUT_i[s];
          HRESP_o     = HRESP_i[s];
          HRDATA_o    = rdata_v[s];
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_region_decoder_mux.sv
// Directed bench for ahb_region_decoder_mux: 2 slaves, 6 regions.
//   r0=[0000,0004)->s0  r1=[4001,4002)->s1  r2=[1000,1004)->s0 (boot-masked)
//   r3=[4000,4010)->s0  r4=[6000,6001)->idx3 (default)  r5=[7000,7000) disabled
module tb_ahb_region_decoder_mux;
  localparam logic [31:0] D0 = 32'h1111_2222;
  localparam logic [31:0] D1 = 32'hCAFE_F00D;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        HSEL_i;
  logic [31:0] HADDR_i;
  logic [1:0]  HTRANS_i;
  logic        HREADY_i;
  logic        CFG_BOOT;
  logic [1:0]  HSEL_o;
  logic [1:0]  HREADYOUT_i;
  logic [1:0]  HRESP_i;
  logic [63:0] HRDATA_i;
  logic        HREADYOUT_o;
  logic        HRESP_o;
  logic [31:0] HRDATA_o;
  logic        DEFSLV_ERR_o;
  logic [7:0]  ERRCNT_o;

  int n_run  = 0;
  int n_fail = 0;

  always #5 HCLK = ~HCLK;

  ahb_region_decoder_mux #(
    .NUM_SLV         (2),
    .NUM_REGIONS     (6),
    .SLV_IDX_W       (2),
    .REGION_BASE     ({16'h7000, 16'h6000, 16'h4000, 16'h1000, 16'h4001, 16'h0000}),
    .REGION_LIMIT    ({16'h7000, 16'h6001, 16'h4010, 16'h1004, 16'h4002, 16'h0004}),
    .REGION_SLV      ({2'd1, 2'd3, 2'd0, 2'd0, 2'd1, 2'd0}),
    .REGION_BOOTMASK (6'b000100),
    .ERRCNT_W        (8)
  ) dut (
    .HCLK         (HCLK),
    .HRESET       (HRESET),
    .HSEL_i       (HSEL_i),
    .HADDR_i      (HADDR_i),
    .HTRANS_i     (HTRANS_i),
    .HREADY_i     (HREADY_i),
    .CFG_BOOT     (CFG_BOOT),
    .HSEL_o       (HSEL_o),
    .HREADYOUT_i  (HREADYOUT_i),
    .HRESP_i      (HRESP_i),
    .HRDATA_i     (HRDATA_i),
    .HREADYOUT_o  (HREADYOUT_o),
    .HRESP_o      (HRESP_o),
    .HRDATA_o     (HRDATA_o),
    .DEFSLV_ERR_o (DEFSLV_ERR_o),
    .ERRCNT_o     (ERRCNT_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge HCLK);
    #1;
  endtask

  task automatic ap(input logic sel, input logic [31:0] a, input logic [1:0] tr);
    HSEL_i   = sel;
    HADDR_i  = a;
    HTRANS_i = tr;
  endtask

  // Combinational decode check inside the current cycle (no clock edge).
  task automatic dec(input string tag, input logic sel, input logic [31:0] a, input logic [1:0] exp);
    ap(sel, a, 2'b00);
    #1;
    chk(tag, 32'(HSEL_o), 32'(exp));
  endtask

  initial begin
    HRESET = 1'b1; CFG_BOOT = 1'b0; HREADY_i = 1'b1;
    HREADYOUT_i = 2'b11; HRESP_i = 2'b00; HRDATA_i = {D1, D0};
    ap(1'b0, 32'h0, 2'b00);
    tick; tick;
    chk("rst_rdy",  32'(HREADYOUT_o), 32'd1);
    chk("rst_resp", 32'(HRESP_o), 32'd0);
    chk("rst_rdata", HRDATA_o, 32'd0);
    chk("rst_deferr", 32'(DEFSLV_ERR_o), 32'd0);
    chk("rst_cnt", 32'(ERRCNT_o), 32'd0);
    HRESET = 1'b0;

    // Basic read from s1
    tick;
    ap(1'b1, 32'h4001_0010, 2'b10);
    #1 chk("s1_hsel", 32'(HSEL_o), 32'h2);
    tick;
    ap(1'b0, 32'h0, 2'b00);
    #1 chk("s1_rdata", HRDATA_o, D1);
    chk("s1_resp", 32'(HRESP_o), 32'd0);
    chk("s1_rdy", 32'(HREADYOUT_o), 32'd1);

    // Decode patterns and boundaries
    tick;
    dec("ovl_r1_wins", 1'b1, 32'h4001_8000, 2'b10);
    dec("r3_only",     1'b1, 32'h4005_0000, 2'b01);
    dec("r0_top",      1'b1, 32'h0003_FFFF, 2'b01);
    dec("r0_limit",    1'b1, 32'h0004_0000, 2'b00);
    dec("idx_oob",     1'b1, 32'h6000_0000, 2'b00);
    dec("disabled",    1'b1, 32'h7000_0000, 2'b00);
    dec("hsel_low",    1'b0, 32'h4001_0000, 2'b00);
    tick;
    ap(1'b0, 32'h0, 2'b00);

    // Unmapped NONSEQ -> two-cycle ERROR
    tick;
    ap(1'b1, 32'h5000_0000, 2'b10);
    #1 chk("unm_hsel", 32'(HSEL_o), 32'd0);
    tick;
    ap(1'b0, 32'h0, 2'b00); HREADY_i = 1'b0;
    #1 chk("e1_rdy",  32'(HREADYOUT_o), 32'd0);
    chk("e1_resp", 32'(HRESP_o), 32'd1);
    chk("e1_pulse", 32'(DEFSLV_ERR_o), 32'd1);
    chk("e1_cnt", 32'(ERRCNT_o), 32'd1);
    tick;
    HREADY_i = 1'b1;
    #1 chk("e2_rdy",  32'(HREADYOUT_o), 32'd1);
    chk("e2_resp", 32'(HRESP_o), 32'd1);
    chk("e2_pulse", 32'(DEFSLV_ERR_o), 32'd0);
    tick;
    chk("idle_resp", 32'(HRESP_o), 32'd0);
    // IDLE transfer to unmapped address -> OKAY, no count
    ap(1'b1, 32'h5000_0000, 2'b00);
    tick;
    ap(1'b0, 32'h0, 2'b00);
    #1 chk("idl_rdy", 32'(HREADYOUT_o), 32'd1);
    chk("idl_resp", 32'(HRESP_o), 32'd0);
    chk("idl_cnt", 32'(ERRCNT_o), 32'd1);

    // Boot mask
    CFG_BOOT = 1'b1;
    ap(1'b1, 32'h1000_0000, 2'b10);
    #1 chk("boot_hsel", 32'(HSEL_o), 32'd0);
    tick;
    ap(1'b0, 32'h0, 2'b00); HREADY_i = 1'b0;
    #1 chk("boot_resp", 32'(HRESP_o), 32'd1);
    chk("boot_cnt", 32'(ERRCNT_o), 32'd2);
    tick;
    HREADY_i = 1'b1;
    tick;
    CFG_BOOT = 1'b0;
    ap(1'b1, 32'h1000_0000, 2'b10);
    #1 chk("noboot_hsel", 32'(HSEL_o), 32'h1);
    tick;
    // Raising CFG_BOOT in the data phase must not re-route it
    ap(1'b0, 32'h0, 2'b00); CFG_BOOT = 1'b1;
    #1 chk("noboot_rdata", HRDATA_o, D0);
    chk("noboot_resp", 32'(HRESP_o), 32'd0);
    CFG_BOOT = 1'b0;

    // Wait states from s1 while an unmapped NONSEQ is pending
    tick;
    ap(1'b1, 32'h4001_0000, 2'b10);
    tick;
    HREADYOUT_i = 2'b01; HREADY_i = 1'b0;
    ap(1'b1, 32'h5000_0000, 2'b10);
    for (int i = 0; i < 3; i++) begin
      #1 chk("ws_rdy", 32'(HREADYOUT_o), 32'd0);
      chk("ws_pulse", 32'(DEFSLV_ERR_o), 32'd0);
      tick;
    end
    HREADYOUT_i = 2'b11; HREADY_i = 1'b1;
    #1 chk("ws_done_rdata", HRDATA_o, D1);
    chk("ws_done_rdy", 32'(HREADYOUT_o), 32'd1);
    chk("ws_cnt", 32'(ERRCNT_o), 32'd2);
    tick;
    HREADY_i = 1'b0;
    #1 chk("ws_e1_pulse", 32'(DEFSLV_ERR_o), 32'd1);
    chk("ws_e1_cnt", 32'(ERRCNT_o), 32'd3);
    tick;
    HREADY_i = 1'b1;
    #1 chk("b2b_e2_resp", 32'(HRESP_o), 32'd1);
    chk("b2b_e2_rdy", 32'(HREADYOUT_o), 32'd1);
    tick;
    HREADY_i = 1'b0;
    #1 chk("b2b_e1_rdy", 32'(HREADYOUT_o), 32'd0);
    chk("b2b_e1_pulse", 32'(DEFSLV_ERR_o), 32'd1);
    chk("b2b_e1_cnt", 32'(ERRCNT_o), 32'd4);

    // Saturation: 300 more errors from a count of 4
    for (int i = 0; i < 300; i++) begin
      HREADY_i = 1'b0;
      tick;
      HREADY_i = 1'b1;
      tick;
    end
    HREADY_i = 1'b0;
    #1 chk("sat_cnt", 32'(ERRCNT_o), 32'd255);
    chk("sat_pulse", 32'(DEFSLV_ERR_o), 32'd1);

    // Reset in ERR1
    HRESET = 1'b1;
    tick;
    chk("rst_e1_rdy",  32'(HREADYOUT_o), 32'd1);
    chk("rst_e1_resp", 32'(HRESP_o), 32'd0);
    chk("rst_e1_cnt",  32'(ERRCNT_o), 32'd0);
    chk("rst_e1_pulse", 32'(DEFSLV_ERR_o), 32'd0);
    HRESET = 1'b0; HREADY_i = 1'b1;
    ap(1'b0, 32'h0, 2'b00);
    tick;

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
